reg_exchange_array: RTL and testbench
=====================================

REG_EXCHANGE_ARRAY -- requirements
Module: reg_exchange_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of each register.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of registers (power of two, >=2); AW = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_op  input  2  00 LOAD, 01 SWAP, 10 ROTL, 11 ROTR.
REQ-008 SHALL have port idx_a  input  AW  LOAD target / SWAP first index.
REQ-009 SHALL have port idx_b  input  AW  SWAP second index.
REQ-010 SHALL have port cmd_amt  input  AW  rotate amount in positions.
REQ-011 SHALL have port wr_data  input  WIDTH  LOAD data.
REQ-012 SHALL have port rd_idx  input  AW  read select.
REQ-013 SHALL have port rd_data  output  WIDTH  combinational value of reg[rd_idx].
REQ-014 SHALL have port done  output  1  one-cycle pulse on command completion.
REQ-015 SHALL have port xchg_cnt  output  16  completed SWAP/ROTL/ROTR count.

Function
REQ-016 SHALL accept a command on a posedge where cmd_valid && cmd_ready.
REQ-017 SHALL implement FSM states IDLE and ROT; cmd_ready = 1 only in IDLE with rst low.
REQ-018 LOAD SHALL write reg[idx_a] <= wr_data on the accept edge; other registers unchanged.
REQ-019 SWAP SHALL exchange reg[idx_a] and reg[idx_b] simultaneously on the accept edge (both read old values; no lost value).
REQ-020 SWAP with idx_a == idx_b SHALL leave all registers unchanged but still complete and count.
REQ-021 ROTL SHALL shift reg[i] <= reg[i-1 mod DEPTH] (reg[0] <= reg[DEPTH-1]) once per cycle; ROTR SHALL shift reg[i] <= reg[i+1 mod DEPTH].
REQ-022 ROTL/ROTR with cmd_amt = k > 0 SHALL perform the first shift on the accept edge, enter ROT, perform remaining k-1 shifts on the next k-1 edges, then return to IDLE; cmd_ready low for exactly k-1 cycles.
REQ-023 ROTL/ROTR with cmd_amt = 0 SHALL change no register, stay in IDLE, and complete like SWAP.
REQ-024 done SHALL assert for exactly one cycle, in the cycle after the edge performing the command's last update (or accept edge for LOAD/SWAP/amt 0).
REQ-025 Back-to-back LOAD/SWAP commands SHALL be accepted every cycle, each producing its own done pulse.
REQ-026 Command inputs SHALL be ignored while cmd_ready is low; rotate direction and amount are latched at accept.
REQ-027 rd_data SHALL reflect register contents after the most recent edge, including mid-rotation.

Reset
REQ-028 On rst high SHALL immediately clear all registers to 0, state to IDLE, done to 0, xchg_cnt to 0, and force cmd_ready to 0.
REQ-029 Reset asserted mid-rotation SHALL abort the rotation with no done pulse; first accept possible on the first posedge after rst deasserts.

Configuration
REQ-030 With macro XCHG_COUNT_EN defined, xchg_cnt SHALL increment by 1 (wrapping 0xFFFF -> 0) in the cycle done pulses for SWAP, ROTL, ROTR; LOAD does not count.
REQ-031 Without XCHG_COUNT_EN, xchg_cnt SHALL be tied to 0 and no counter register is built.

Verification
REQ-032 Reset, LOAD 0xA1..0xA4 to idx 0..3 -> rd_data reads 0xA1,0xA2,0xA3,0xA4; four done pulses; xchg_cnt 0.
REQ-033 SWAP idx_a=0, idx_b=3 on above -> reg = {0xA4,0xA2,0xA3,0xA1}; done one cycle later; xchg_cnt 1 (macro on).
REQ-034 ROTL amt=2 on {0x01,0x02,0x03,0x04} -> cmd_ready low 1 cycle, final reg = {0x03,0x04,0x01,0x02}, single done.
REQ-035 ROTR amt=0 and SWAP idx_a=idx_b=2 -> contents unchanged, two done pulses, xchg_cnt +2.
REQ-036 ROTR amt=3 with rst pulsed after first shift -> all regs 0, no done, cmd_ready 0 during rst, 1 after.
REQ-037 Preload xchg_cnt to 0xFFFF via 65535 SWAPs, one more SWAP -> xchg_cnt 0x0000; without macro always 0.

Source files
------------

// File: rtl/reg_exchange_array_if.sv
// reg_exchange_array_if: command/read bus for reg_exchange_array
// Command side: cmd_valid/cmd_ready handshake with cmd_op, idx_a, idx_b, cmd_amt, wr_data.
// Read side: rd_idx selects, rd_data returns; done pulses per completed command; xchg_cnt counts exchanges.
interface reg_exchange_array_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  localparam int AW = $clog2(DEPTH);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    idx_a;
  logic [AW-1:0]    idx_b;
  logic [AW-1:0]    cmd_amt;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  logic [15:0]      xchg_cnt;
  modport master (output cmd_valid, cmd_op, idx_a, idx_b, cmd_amt, wr_data, rd_idx,
                  input cmd_ready, rd_data, done, xchg_cnt);
  modport slave  (input cmd_valid, cmd_op, idx_a, idx_b, cmd_amt, wr_data, rd_idx,
                  output cmd_ready, rd_data, done, xchg_cnt);
endinterface

// File: rtl/reg_exchange_array.sv
// reg_exchange_array: register file with LOAD, SWAP and multi-cycle ROTL/ROTR commands
// Ports: clk, rst (async active-high), bus (reg_exchange_array_if.slave).
// Macro XCHG_COUNT_EN builds the 16-bit SWAP/ROTL/ROTR completion counter; otherwise xchg_cnt is 0.
module reg_exchange_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  reg_exchange_array_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ROT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rl [DEPTH];
  logic [WIDTH-1:0] rr [DEPTH];
  logic [AW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             accept;
  for (genvar i = 0; i < DEPTH; i++) begin : g_rot
    assign rl[i] = regs_q[(i + DEPTH - 1) % DEPTH];
    assign rr[i] = regs_q[(i + 1) % DEPTH];
  end
  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.rd_data   = regs_q[bus.rd_idx];
  assign bus.done      = done_q;
  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (state_q == ROT) begin
      regs_d = dir_q ? rr : rl;
      rem_d  = rem_q - AW'(1);
      if (rem_q == AW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (accept) begin
      case (bus.cmd_op)
        2'b00: begin
          regs_d[bus.idx_a] = bus.wr_data;
          done_d            = 1'b1;
        end
        2'b01: begin
          regs_d[bus.idx_a] = regs_q[bus.idx_b];
          regs_d[bus.idx_b] = regs_q[bus.idx_a];
          done_d            = 1'b1;
        end
        default: begin
          // cmd_op[0] selects ROTR; first shift happens on the accept edge
          dir_d = bus.cmd_op[0];
          if (bus.cmd_amt == '0) done_d = 1'b1;
          else begin
            regs_d = bus.cmd_op[0] ? rr : rl;
            rem_d  = bus.cmd_amt - AW'(1);
            if (bus.cmd_amt == AW'(1)) done_d = 1'b1;
            else state_d = ROT;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      regs_q  <= '{default: '0};
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
`ifdef XCHG_COUNT_EN
  logic [15:0] cnt_q;
  logic        inc;
  // every completion counts except a LOAD accepted from IDLE
  assign inc = done_d && !(state_q == IDLE && bus.cmd_op == 2'b00);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + 16'd1;
  end
  assign bus.xchg_cnt = cnt_q;
`else
  assign bus.xchg_cnt = '0;
`endif
endmodule

// File: tb/tb_reg_exchange_array.sv
// tb_reg_exchange_array: directed self-checking bench for reg_exchange_array
module tb_reg_exchange_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  reg_exchange_array_if #(.WIDTH(8), .DEPTH(4)) bus ();
  reg_exchange_array #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [15:0] ce(input logic [15:0] x);
`ifdef XCHG_COUNT_EN
    return x;
`else
    return 16'h0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs(input string tag, input logic [31:0] e);
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'h0, bus.rd_data}, {24'h0, e[i*8 +: 8]});
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] amt, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.idx_a     = a;
    bus.idx_b     = b;
    bus.cmd_amt   = amt;
    bus.wr_data   = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.idx_a = '0;
    bus.idx_b = '0;
    bus.cmd_amt = '0;
    bus.wr_data = '0;
    bus.rd_idx = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_cnt", {16'h0, bus.xchg_cnt}, 32'h0);
    chk_regs("rst", 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'h0, bus.cmd_ready}, 32'h1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 2'(i), 2'd0, 2'd0, 8'hA1 + 8'(i));
      chk($sformatf("load_done%0d", i), {31'h0, bus.done}, 32'h1);
    end
    @(negedge clk);
    chk("load_done_clear", {31'h0, bus.done}, 32'h0);
    chk_regs("load", 32'hA4A3A2A1);
    chk("load_cnt", {16'h0, bus.xchg_cnt}, 32'h0);
    issue(2'b01, 2'd0, 2'd3, 2'd0, 8'h00);
    chk("swap_done", {31'h0, bus.done}, 32'h1);
    chk("swap_cnt", {16'h0, bus.xchg_cnt}, {16'h0, ce(16'd1)});
    chk_regs("swap", 32'hA1A3A2A4);
    @(negedge clk);
    chk("swap_done_clear", {31'h0, bus.done}, 32'h0);
    for (int i = 0; i < 4; i++) issue(2'b00, 2'(i), 2'd0, 2'd0, 8'h01 + 8'(i));
    chk("load_nocount", {16'h0, bus.xchg_cnt}, {16'h0, ce(16'd1)});
    @(negedge clk);
    bus.rd_idx = 2'd0;
    issue(2'b10, 2'd0, 2'd0, 2'd2, 8'h00);
    chk("rotl_mid_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("rotl_mid_done", {31'h0, bus.done}, 32'h0);
    chk("rotl_mid_r0", {24'h0, bus.rd_data}, 32'h04);
    issue(2'b00, 2'd0, 2'd0, 2'd0, 8'hFF);
    chk("rotl_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("rotl_done", {31'h0, bus.done}, 32'h1);
    chk("rotl_cnt", {16'h0, bus.xchg_cnt}, {16'h0, ce(16'd2)});
    chk_regs("rotl", 32'h02010403);
    @(negedge clk);
    chk("rotl_single_done", {31'h0, bus.done}, 32'h0);
    issue(2'b11, 2'd0, 2'd0, 2'd0, 8'h00);
    chk("rotr0_done", {31'h0, bus.done}, 32'h1);
    chk("rotr0_ready", {31'h0, bus.cmd_ready}, 32'h1);
    issue(2'b01, 2'd2, 2'd2, 2'd0, 8'h00);
    chk("swap_same_done", {31'h0, bus.done}, 32'h1);
    chk("noop_cnt", {16'h0, bus.xchg_cnt}, {16'h0, ce(16'd4)});
    chk_regs("noop", 32'h02010403);
    @(negedge clk);
    bus.rd_idx = 2'd0;
    issue(2'b11, 2'd0, 2'd0, 2'd3, 8'h00);
    chk("rotr_mid_r0", {24'h0, bus.rd_data}, 32'h04);
    chk("rotr_mid_ready", {31'h0, bus.cmd_ready}, 32'h0);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("abort_cnt", {16'h0, bus.xchg_cnt}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk_regs("abort", 32'h0);
    @(negedge clk);
    chk("abort_done_hold", {31'h0, bus.done}, 32'h0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'h0, bus.cmd_ready}, 32'h1);
    @(negedge clk);
    chk("abort_no_done", {31'h0, bus.done}, 32'h0);
    chk_regs("abort_after", 32'h0);
    for (int i = 0; i < 65535; i++) issue(2'b01, 2'd0, 2'd1, 2'd0, 8'h00);
    chk("cnt_ffff", {16'h0, bus.xchg_cnt}, {16'h0, ce(16'hFFFF)});
    issue(2'b01, 2'd0, 2'd1, 2'd0, 8'h00);
    chk("cnt_wrap", {16'h0, bus.xchg_cnt}, 32'h0);
    chk("wrap_done", {31'h0, bus.done}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
